// File: rtl/sram_ctrl.sv
// sram_ctrl
// ---------
// Bridges separate read and write request channels onto a single-port SRAM
// with registered read data. One transaction is in flight at a time; when
// both channels request together in IDLE the grant alternates between them,
// starting with read after reset.
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. A source keeps valid and its payload
// stable until that edge; ready may depend combinationally on valid.
//
// Optional feature: define SRAM_CTRL_RANGE_CHECK_EN to reject byte addresses
// with any bit above addr_width+1 set (no SRAM access, read data 0, write
// dropped, sticky oob_error). Without it the upper address bits alias and
// oob_error is tied to 0.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   rd_req_valid/ready/addr      read request (32-bit byte address)
//   rd_resp_valid/ready/data     read response
//   wr_req_valid/ready/addr/data/strobe   write request with byte enables
//   wr_resp_valid/ready          write completion
//   oob_error                    sticky out-of-range flag
//   sram_en/wen/wmask/addr/din   SRAM command, sram_dout registered read data
//   dbg_state                    current FSM state (IDLE=0, RD_WAIT=1,
//                                RD_RESP=2, WR_RESP=3)
module sram_ctrl #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [31:0]           rd_req_addr,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [data_width-1:0] rd_resp_data,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [31:0]           wr_req_addr,
    input  logic [data_width-1:0] wr_req_data,
    input  logic [3:0]            wr_req_strobe,
    output logic                  wr_resp_valid,
    input  logic                  wr_resp_ready,
    output logic                  oob_error,
    output logic                  sram_en,
    output logic                  sram_wen,
    output logic [3:0]            sram_wmask,
    output logic [addr_width-1:0] sram_addr,
    output logic [data_width-1:0] sram_din,
    input  logic [data_width-1:0] sram_dout,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2,
        WR_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_rd;     // 1 when the last served channel was read
    logic                  r_rd_oob;      // in-flight read was out of range
    logic [data_width-1:0] r_rd_data;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_rd_oob;
    logic                  w_wr_oob;

    // Byte-offset bits never select a word; upper bits only matter to the
    // range check.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{rd_req_addr[1:0], wr_req_addr[1:0],
                                  rd_req_addr[31:addr_width+2],
                                  wr_req_addr[31:addr_width+2]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic r_oob_error;

    assign w_rd_oob = |rd_req_addr[31:addr_width+2];
    assign w_wr_oob = |wr_req_addr[31:addr_width+2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_oob_error <= 1'b0;
        end else if ((w_rd_fire && w_rd_oob) || (w_wr_fire && w_wr_oob)) begin
            r_oob_error <= 1'b1;
        end
    end

    assign oob_error = r_oob_error;
`else
    assign w_rd_oob  = 1'b0;
    assign w_wr_oob  = 1'b0;
    assign oob_error = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        sram_en      = 1'b0;
        sram_wen     = 1'b0;
        sram_addr    = rd_req_addr[addr_width+1:2];
        sram_wmask   = wr_req_strobe;
        sram_din     = wr_req_data;
        // Write only beats read when both request and read was served last.
        w_grant_rd   = rd_req_valid && (!wr_req_valid || !r_last_rd);
        w_grant_wr   = wr_req_valid && !w_grant_rd;

        case (r_state)
            IDLE: begin
                // Readys are gated by reset so nothing handshakes while the
                // block is held in reset.
                if (!reset) begin
                    if (w_grant_rd) begin
                        rd_req_ready = 1'b1;
                        sram_en      = !w_rd_oob;
                        w_next_state = RD_WAIT;
                    end else if (w_grant_wr) begin
                        wr_req_ready = 1'b1;
                        sram_en      = !w_wr_oob;
                        sram_wen     = 1'b1;
                        sram_addr    = wr_req_addr[addr_width+1:2];
                        w_next_state = WR_RESP;
                    end
                end
            end
            RD_WAIT: w_next_state = RD_RESP;
            RD_RESP: if (rd_resp_ready) w_next_state = IDLE;
            WR_RESP: if (wr_resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_rd_fire = rd_req_valid && rd_req_ready;
    assign w_wr_fire = wr_req_valid && wr_req_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last_rd <= 1'b0;
            r_rd_oob  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_rd_fire) begin
                r_last_rd <= 1'b1;
                r_rd_oob  <= w_rd_oob;
            end else if (w_wr_fire) begin
                r_last_rd <= 1'b0;
            end
            // SRAM output is valid the cycle after the access; capture it
            // once so the response stays stable under backpressure.
            if (r_state == RD_WAIT) begin
                r_rd_data <= r_rd_oob ? '0 : sram_dout;
            end
        end
    end

    assign rd_resp_valid = (r_state == RD_RESP);
    assign wr_resp_valid = (r_state == WR_RESP);
    assign rd_resp_data  = r_rd_data;
    assign dbg_state     = r_state;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter addr_width, default 8, meaning SRAM word-address width (SRAM depth = 2^addr_width words).
REQ-002 SHALL have parameter data_width, default 32, meaning data width; the value is fixed at 32.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as the ports below:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  rd_req_valid / rd_req_ready  in / out  1 / 1  read-request handshake
  rd_req_addr  in  32  byte address
  rd_resp_valid / rd_resp_ready  out / in  1 / 1  read-response handshake
  rd_resp_data  out  32  read data
  wr_req_valid / wr_req_ready  in / out  1 / 1  write-request handshake
  wr_req_addr  in  32  byte address
  wr_req_data  in  32  write data
  wr_req_strobe  in  4  byte enables
  wr_resp_valid / wr_resp_ready  out / in  1 / 1  write-completion handshake
  oob_error  out  1  sticky out-of-range flag
  sram_en, sram_wen  out  1 each  SRAM enable and write enable
  sram_wmask  out  4  SRAM byte mask
  sram_addr  out  addr_width  SRAM word address
  sram_din  out  32  SRAM write data
  sram_dout  in  32  SRAM registered read data

Function
REQ-004 SHALL use a state machine with states IDLE, RD_WAIT, RD_RESP and WR_RESP, allowing at most one outstanding transaction.
REQ-005 SHALL, in IDLE only, drive the ready of the granted channel high combinationally; every other ready SHALL be 0.
REQ-006 SHALL arbitrate round-robin when both request valids are high in IDLE: grant the channel not served last; after reset, read wins.
REQ-007 SHALL, on a read handshake, drive sram_en=1, sram_wen=0 and sram_addr=rd_req_addr[addr_width+1:2] in the same cycle, then go to RD_WAIT.
REQ-008 SHALL, in RD_WAIT, register sram_dout into rd_resp_data and go to RD_RESP.
REQ-009 SHALL, in RD_RESP, hold rd_resp_valid=1 with rd_resp_data stable until rd_resp_ready=1, then return to IDLE.
REQ-010 SHALL give a read latency of exactly 2 cycles from request handshake to rd_resp_valid when no backpressure is applied.
REQ-011 SHALL, on a write handshake, drive sram_en=1, sram_wen=1, sram_wmask=wr_req_strobe, sram_din=wr_req_data and the address as in REQ-007 in the same cycle, then go to WR_RESP.
REQ-012 SHALL, in WR_RESP, hold wr_resp_valid=1 until wr_resp_ready=1, then return to IDLE.
REQ-013 SHALL accept no new request in the cycle of a response handshake; the earliest next accept is the following cycle in IDLE.
REQ-014 SHALL ignore address bits [1:0]; a write with wr_req_strobe=0 SHALL still perform the SRAM cycle and the response.
REQ-015 SHALL drive sram_en=0 in every cycle without a request handshake; sram_wen, sram_wmask, sram_addr and sram_din are don't-care while sram_en=0.

Reset
REQ-016 SHALL, on reset assertion at any time, asynchronously force state=IDLE, all valids and readys=0, rd_resp_data=0, oob_error=0, sram_en=0, and the round-robin pointer to read-first.
REQ-017 SHALL silently drop any transaction in flight at reset; no response is produced after reset deasserts.

Configuration
REQ-018 SHALL, with SRAM_CTRL_RANGE_CHECK_EN defined, treat a request with any address bit above addr_width+1 set as out-of-range: sram_en=0 for that request, a read returns rd_resp_data=32'h0, a write is dropped, the normal response handshake still occurs, and oob_error is set until reset.
REQ-019 SHALL, without SRAM_CTRL_RANGE_CHECK_EN, ignore upper address bits (the address aliases) and tie oob_error to 0.

Verification
REQ-020 SHALL cover a write to 0x10 with data 0xA5A5_1234 and strobe 0xF, followed by a read of 0x10 -> sram_addr=4 on both accesses; rd_resp_data=0xA5A5_1234 exactly 2 cycles after the read handshake.
REQ-021 SHALL cover a write to 0x10 with data 0xFFFF_FFFF and strobe 0x2 over the contents 0x0 -> sram_wmask=0x2; a subsequent read returns 0x0000_FF00.
REQ-022 SHALL cover read and write valids held high together for 4 transactions -> grants alternate R, W, R, W; never two SRAM cycles in one cycle.
REQ-023 SHALL cover rd_resp_ready held low for 5 cycles -> rd_resp_valid and data stable, rd_req_ready=0 and sram_en=0 throughout.
REQ-024 SHALL cover reset asserted in RD_WAIT -> all outputs 0 immediately, with no rd_resp_valid after release.
REQ-025 SHALL cover, with the macro defined and addr_width=8, a read of 0x400 -> sram_en stays 0, rd_resp_data=0, oob_error=1 until reset.
